// File: rtl/alu_exec.sv
// Execute-stage ALU: condition check, ARM data-processing ops in one cycle,
// and a 32-cycle shift-add multiply, with registered write-back outputs.
module alu_exec (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        is_mul_i,
  input  logic [3:0]  opcode_i,
  input  logic [3:0]  cond_i,
  input  logic        set_flags_i,
  input  logic [3:0]  dest_sel_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [3:0]  flags_in_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [3:0]  wr_sel_o,
  output logic        wr_en_o,
  output logic [3:0]  flags_out_o
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] MUL_ITERS = CW'(32);

  // EXEC is the single evaluate cycle between acceptance and the done cycle
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    flags_q, flags_d, opcode_q, opcode_d, cond_q, cond_d, dest_q, dest_d;
  logic          set_q, set_d, is_mul_q, is_mul_d;
  logic          busy_q, busy_d, done_q, done_d, wr_en_q, wr_en_d;
  logic [W-1:0]  result_q, result_d;
  logic [3:0]    wr_sel_q, wr_sel_d, flags_out_q, flags_out_d;

  logic [W-1:0]  x_c, y_c, logic_res_c, dp_res_c;
  logic          cin_c, is_arith_c, is_cmp_c, ovf_c, cond_ok_c;
  logic [W:0]    sum_c;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: cond_pass = z;
      4'h1: cond_pass = !z;
      4'h2: cond_pass = cf;
      4'h3: cond_pass = !cf;
      4'h4: cond_pass = n;
      4'h5: cond_pass = !n;
      4'h6: cond_pass = v;
      4'h7: cond_pass = !v;
      4'h8: cond_pass = cf && !z;
      4'h9: cond_pass = !cf || z;
      4'hA: cond_pass = (n == v);
      4'hB: cond_pass = (n != v);
      4'hC: cond_pass = !z && (n == v);
      4'hD: cond_pass = z || (n != v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // Data-processing datapath on the captured operands
  always_comb begin
    is_cmp_c   = (opcode_q[3:2] == 2'b10);
    is_arith_c = 1'b0;
    x_c        = a_q;
    y_c        = b_q;
    cin_c      = 1'b0;
    case (opcode_q)
      4'h2, 4'hA: begin is_arith_c = 1'b1; y_c = ~b_q; cin_c = 1'b1; end
      4'h3:       begin is_arith_c = 1'b1; x_c = b_q; y_c = ~a_q; cin_c = 1'b1; end
      4'h4, 4'hB: begin is_arith_c = 1'b1; end
      4'h5:       begin is_arith_c = 1'b1; cin_c = flags_q[1]; end
      4'h6:       begin is_arith_c = 1'b1; y_c = ~b_q; cin_c = flags_q[1]; end
      4'h7:       begin is_arith_c = 1'b1; x_c = b_q; y_c = ~a_q; cin_c = flags_q[1]; end
      default: ;
    endcase
    sum_c = {1'b0, x_c} + {1'b0, y_c} + (W+1)'(cin_c);
    ovf_c = (x_c[W-1] == y_c[W-1]) && (sum_c[W-1] != x_c[W-1]);
    case (opcode_q)
      4'h0, 4'h8: logic_res_c = a_q & b_q;
      4'h1, 4'h9: logic_res_c = a_q ^ b_q;
      4'hC:       logic_res_c = a_q | b_q;
      4'hD:       logic_res_c = b_q;
      4'hE:       logic_res_c = a_q & ~b_q;
      default:    logic_res_c = ~b_q;
    endcase
    dp_res_c  = is_arith_c ? sum_c[W-1:0] : logic_res_c;
    cond_ok_c = cond_pass(cond_q, flags_q);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    count_d     = count_q;
    flags_d     = flags_q;
    opcode_d    = opcode_q;
    cond_d      = cond_q;
    dest_d      = dest_q;
    set_d       = set_q;
    is_mul_d    = is_mul_q;
    result_d    = result_q;
    wr_sel_d    = wr_sel_q;
    wr_en_d     = wr_en_q;
    flags_out_d = flags_out_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d      = op_a_i;
          b_d      = op_b_i;
          flags_d  = flags_in_i;
          opcode_d = opcode_i;
          cond_d   = cond_i;
          set_d    = set_flags_i;
          dest_d   = dest_sel_i;
          is_mul_d = is_mul_i;
          acc_d    = '0;
          count_d  = '0;
          state_d  = (is_mul_i && cond_pass(cond_i, flags_in_i)) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        state_d  = S_DONE;
        wr_sel_d = dest_q;
        if (!cond_ok_c || is_mul_q) begin
          result_d    = '0;
          wr_en_d     = 1'b0;
          flags_out_d = flags_q;
        end else begin
          result_d    = dp_res_c;
          wr_en_d     = !is_cmp_c;
          flags_out_d = flags_q;
          if (set_q || is_cmp_c) begin
            flags_out_d[3] = dp_res_c[W-1];
            flags_out_d[2] = (dp_res_c == '0);
            if (is_arith_c) begin
              flags_out_d[1] = sum_c[W];
              flags_out_d[0] = ovf_c;
            end
          end
        end
      end
      S_MUL: begin
        if (count_q == MUL_ITERS) begin
          state_d     = S_DONE;
          result_d    = acc_q;
          wr_sel_d    = dest_q;
          wr_en_d     = 1'b1;
          flags_out_d = flags_q;
          if (set_q) flags_out_d[3:2] = {acc_q[W-1], acc_q == '0};
        end else begin
          if (b_q[0]) acc_d = acc_q + a_q;
          a_d     = a_q << 1;
          b_d     = b_q >> 1;
          count_d = count_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      flags_q     <= '0;
      opcode_q    <= '0;
      cond_q      <= '0;
      dest_q      <= '0;
      set_q       <= 1'b0;
      is_mul_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      wr_sel_q    <= '0;
      wr_en_q     <= 1'b0;
      flags_out_q <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      flags_q     <= flags_d;
      opcode_q    <= opcode_d;
      cond_q      <= cond_d;
      dest_q      <= dest_d;
      set_q       <= set_d;
      is_mul_q    <= is_mul_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      wr_sel_q    <= wr_sel_d;
      wr_en_q     <= wr_en_d;
      flags_out_q <= flags_out_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign wr_sel_o    = wr_sel_q;
  assign wr_en_o     = wr_en_q;
  assign flags_out_o = flags_out_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: hand-computed vectors for DP ops, conditions,
// multiply latency, mid-op start rejection and reset abort.
module tb_alu_exec;

  logic        clk, rst, start, is_mul, set_flags;
  logic [3:0]  opcode, cond, dest_sel, flags_in;
  logic [31:0] op_a, op_b;
  logic        busy, done, wr_en;
  logic [31:0] result;
  logic [3:0]  wr_sel, flags_out;

  int checks = 0;
  int errors = 0;
  int lat;
  logic busy_all;

  alu_exec dut (
    .clock_i(clk), .reset_i(rst), .start_i(start), .is_mul_i(is_mul),
    .opcode_i(opcode), .cond_i(cond), .set_flags_i(set_flags),
    .dest_sel_i(dest_sel), .op_a_i(op_a), .op_b_i(op_b), .flags_in_i(flags_in),
    .busy_o(busy), .done_o(done), .result_o(result), .wr_sel_o(wr_sel),
    .wr_en_o(wr_en), .flags_out_o(flags_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for idle, then present one request for exactly one rising edge
  task automatic issue(input logic m, input logic [3:0] op, input logic [3:0] c,
                       input logic s, input logic [3:0] dst, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] fl);
    @(negedge clk);
    for (int i = 0; i < 64 && busy; i++) @(negedge clk);
    is_mul = m; opcode = op; cond = c; set_flags = s; dest_sel = dst;
    op_a = a; op_b = b; flags_in = fl; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count edges until done; optionally pulse start at cycle inj while busy
  task automatic wait_done(input int inj);
    lat = 0;
    busy_all = 1'b1;
    while (!done && lat < 100) begin
      start = (lat == inj);
      @(posedge clk);
      #1;
      lat++;
      if (!busy) busy_all = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic check_out(input string tag, input int exp_lat, input logic [31:0] res,
                           input logic we, input logic [3:0] fl, input logic [3:0] sel);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, result, res);
    check({tag, " wr_en"}, 32'(wr_en), 32'(we));
    check({tag, " flags"}, 32'(flags_out), 32'(fl));
    check({tag, " wr_sel"}, 32'(wr_sel), 32'(sel));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; is_mul = 1'b0; set_flags = 1'b0;
    opcode = '0; cond = '0; dest_sel = '0; flags_in = '0; op_a = '0; op_b = '0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    check("reset wr_en", 32'(wr_en), 32'd0);
    check("reset flags", 32'(flags_out), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // ADD with S: carry out and zero
    issue(1'b0, 4'h4, 4'hE, 1'b1, 4'd3, 32'hFFFF_FFFF, 32'h1, 4'b0000);
    wait_done(-1);
    check_out("add", 1, 32'h0, 1'b1, 4'b0110, 4'd3);
    check("add busy", 32'(busy_all), 32'd1);
    @(posedge clk); #1;
    check("add done pulse", 32'(done), 32'd0);
    check("add result hold", result, 32'h0);

    // SUB with S: signed overflow, no borrow
    issue(1'b0, 4'h2, 4'hE, 1'b1, 4'd4, 32'h8000_0000, 32'h1, 4'b0000);
    wait_done(-1);
    check_out("sub", 1, 32'h7FFF_FFFF, 1'b1, 4'b0011, 4'd4);

    // CMP updates flags without S and suppresses write
    issue(1'b0, 4'hA, 4'hE, 1'b0, 4'd5, 32'd5, 32'd5, 4'b0000);
    wait_done(-1);
    check_out("cmp", 1, 32'h0, 1'b0, 4'b0110, 4'd5);

    // MOVNE with Z set fails its condition
    issue(1'b0, 4'hD, 4'h1, 1'b1, 4'd6, 32'h0, 32'h1234, 4'b0110);
    wait_done(-1);
    check_out("movne", 1, 32'h0, 1'b0, 4'b0110, 4'd6);

    // ADC with carry in crossing into the sign bit
    issue(1'b0, 4'h5, 4'hE, 1'b1, 4'd7, 32'h7FFF_FFFF, 32'h0, 4'b0010);
    wait_done(-1);
    check_out("adc", 1, 32'h8000_0000, 1'b1, 4'b1001, 4'd7);

    // BIC keeps C and V
    issue(1'b0, 4'hE, 4'hE, 1'b1, 4'd8, 32'hFF, 32'h0F, 4'b0011);
    wait_done(-1);
    check_out("bic", 1, 32'hF0, 1'b1, 4'b0011, 4'd8);

    // RSB: 10 - 3, no borrow
    issue(1'b0, 4'h3, 4'hE, 1'b1, 4'd9, 32'd3, 32'd10, 4'b1000);
    wait_done(-1);
    check_out("rsb", 1, 32'd7, 1'b1, 4'b0010, 4'd9);

    // TEQ of equal values: Z set, C and V preserved, no write
    issue(1'b0, 4'h9, 4'hE, 1'b0, 4'd10, 32'hF0F0, 32'hF0F0, 4'b0001);
    wait_done(-1);
    check_out("teq", 1, 32'h0, 1'b0, 4'b0101, 4'd10);

    // MUL without S, with a rejected start pulse mid-operation
    issue(1'b1, 4'h0, 4'hE, 1'b0, 4'd11, 32'h12345, 32'h6789, 4'b1010);
    wait_done(10);
    check_out("mul", 33, 32'h75CC_A2ED, 1'b1, 4'b1010, 4'd11);
    check("mul busy", 32'(busy_all), 32'd1);
    lat = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) lat++;
    end
    check("mul no extra done", 32'(lat), 32'd0);

    // Reset in the middle of a multiply
    issue(1'b1, 4'h0, 4'hE, 1'b0, 4'd12, 32'h3, 32'h5, 4'b0000);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst result", result, 32'h0);
    check("rst wr_en", 32'(wr_en), 32'd0);
    check("rst wr_sel", 32'(wr_sel), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    lat = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) lat++;
    end
    check("rst no done", 32'(lat), 32'd0);
    issue(1'b0, 4'h4, 4'hE, 1'b0, 4'd1, 32'd2, 32'd3, 4'b0000);
    wait_done(-1);
    check_out("post rst add", 1, 32'd5, 1'b1, 4'b0000, 4'd1);

    // MUL whose condition fails finishes in one cycle
    issue(1'b1, 4'h0, 4'h0, 1'b1, 4'd2, 32'd7, 32'd9, 4'b0000);
    wait_done(-1);
    check_out("mul cond fail", 1, 32'h0, 1'b0, 4'b0000, 4'd2);

    // MUL with S: product truncates to zero
    issue(1'b1, 4'h0, 4'hE, 1'b1, 4'd13, 32'h1_0000, 32'h1_0000, 4'b0010);
    wait_done(-1);
    check_out("mul s", 33, 32'h0, 1'b1, 4'b0110, 4'd13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
